// File: rtl/intr_pkg.sv
// Shared types and constants for the intr_ctrl_n interrupt controller.
package intr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] CFG_ENABLE = 2'd0;
   localparam logic [1:0] CFG_MODE   = 2'd1;
   localparam logic [1:0] CFG_PEND   = 2'd2;
   localparam logic [1:0] CFG_PRIO   = 2'd3;

   localparam int unsigned MCAUSE_INT_BIT = 31;
   localparam int unsigned CAUSE_BASE_DEF = 16;

endpackage

// File: rtl/intr_sync_edge.sv
// Per-source synchroniser chain plus one delay flop for rising-edge detection.
module intr_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic clrn_i,
   input  logic a_i,
   output logic y_o,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   d_q;

   always_ff @(posedge clk_i or negedge clrn_i) begin
      if (!clrn_i) begin
         sync_q <= '0;
         d_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
         d_q    <= sync_q[SYNC_STAGES-1];
      end
   end

   assign y_o    = sync_q[SYNC_STAGES-1];
   assign edge_o = sync_q[SYNC_STAGES-1] & ~d_q;

endmodule

// File: rtl/intr_ctrl_n.sv
// Multi-source interrupt controller with claim/ack/eoi handshake.
// Define INTR_PRIO_EN for 2-bit per-source programmable priority.
module intr_ctrl_n
   import intr_pkg::*;
#(
   parameter int unsigned NSRC        = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CAUSE_BASE  = CAUSE_BASE_DEF
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic [NSRC-1:0] intr,
   input  logic            intr_ack,
   input  logic            eoi,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_sel,
   input  logic [31:0]     cfg_wdata,
   output logic [31:0]     cfg_rdata,
   output logic            int_sync,
   output logic [3:0]      int_id,
   output logic [31:0]     int_cause
);

   logic [NSRC-1:0]   y, edg;
   logic [NSRC-1:0]   enable_q, mode_q, pend_q, pend_d;
   logic [NSRC-1:0]   pending, eligible, claim_oh, w1c, ack_clr;
   logic [2*NSRC-1:0] prio_vec;
   state_t            state_q, state_d;
   logic [3:0]        id_q, id_d, win;
   logic [31:0]       cause_q, cause_d;
   logic              unused_wdata;

   assign unused_wdata = ^cfg_wdata;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
      intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i  (clk),
         .clrn_i (clrn),
         .a_i    (intr[gi]),
         .y_o    (y[gi]),
         .edge_o (edg[gi])
      );
   end

   // Highest priority wins; strict '>' keeps ties on the lowest index.
   function automatic logic [3:0] pick(input logic [NSRC-1:0] el,
                                       input logic [2*NSRC-1:0] pr);
      logic [3:0] w;
      logic [1:0] best;
      logic       found;
      w     = '0;
      best  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (el[i] && (!found || pr[2*i +: 2] > best)) begin
            found = 1'b1;
            w     = 4'(i);
            best  = pr[2*i +: 2];
         end
      end
      return w;
   endfunction

`ifdef INTR_PRIO_EN
   logic [2*NSRC-1:0] prio_q;
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         prio_q <= '0;
      else if (cfg_we && cfg_sel == CFG_PRIO)
         prio_q <= cfg_wdata[2*NSRC-1:0];
   end
   assign prio_vec = prio_q;
`else
   assign prio_vec = '0;
`endif

   assign pending  = (mode_q & pend_q) | (~mode_q & y);
   assign eligible = pending & enable_q;
   assign claim_oh = NSRC'(1) << id_q;

   // Latched bits exist only in edge mode; a fresh edge beats any clear.
   always_comb begin
      w1c     = (cfg_we && cfg_sel == CFG_PEND) ? cfg_wdata[NSRC-1:0] : '0;
      ack_clr = (state_q == REQ && intr_ack) ? (claim_oh & mode_q) : '0;
      pend_d  = mode_q & (edg | (pend_q & ~(w1c | ack_clr)));
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      cause_d = cause_q;
      win     = pick(eligible, prio_vec);
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               state_d                 = REQ;
               id_d                    = win;
               cause_d                 = '0;
               cause_d[MCAUSE_INT_BIT] = 1'b1;
               cause_d[30:0]           = 31'(CAUSE_BASE) + 31'(win);
            end
         end
         REQ: begin
            if (intr_ack)
               state_d = SERVICE;
            else if (!(|(eligible & claim_oh)))
               state_d = IDLE;
         end
         SERVICE: begin
            if (eoi)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= IDLE;
         id_q     <= '0;
         cause_q  <= '0;
         enable_q <= '0;
         mode_q   <= '1;
         pend_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         cause_q <= cause_d;
         pend_q  <= pend_d;
         if (cfg_we && cfg_sel == CFG_ENABLE)
            enable_q <= cfg_wdata[NSRC-1:0];
         if (cfg_we && cfg_sel == CFG_MODE)
            mode_q <= cfg_wdata[NSRC-1:0];
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_sel)
         CFG_ENABLE: cfg_rdata = 32'(enable_q);
         CFG_MODE:   cfg_rdata = 32'(mode_q);
         CFG_PEND:   cfg_rdata = 32'(pending);
         CFG_PRIO:   cfg_rdata = 32'(prio_vec);
         default:    cfg_rdata = '0;
      endcase
   end

   assign int_sync  = (state_q == REQ);
   assign int_id    = id_q;
   assign int_cause = cause_q;

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Scoreboard bench for intr_ctrl_n: stimulus queues expected claims, monitor checks each presentation.
module tb_intr_ctrl_n;

   logic        clk = 1'b0;
   logic        clrn;
   logic [7:0]  intr;
   logic        intr_ack, eoi, cfg_we;
   logic [1:0]  cfg_sel;
   logic [31:0] cfg_wdata, cfg_rdata, int_cause;
   logic        int_sync;
   logic [3:0]  int_id;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] cause;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic sync_prev = 1'b0;

   intr_ctrl_n #(.NSRC(8), .SYNC_STAGES(2), .CAUSE_BASE(16)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .intr      (intr),
      .intr_ack  (intr_ack),
      .eoi       (eoi),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .int_sync  (int_sync),
      .int_id    (int_id),
      .int_cause (int_cause)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // Monitor: every rising int_sync must match the oldest expected claim.
   always @(negedge clk) begin
      if (!clrn) begin
         sync_prev = 1'b0;
      end else begin
         if (int_sync && !sync_prev) begin
            if (q.size() == 0) begin
               chk("unexpected_claim", {28'd0, int_id}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("claim_id", {28'd0, int_id}, {28'd0, e.id});
               chk("claim_cause", int_cause, e.cause);
               if (e.cyc >= 0) chk("claim_cycle", cyc, e.cyc);
            end
         end
         sync_prev = int_sync;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
      cfg_sel   = sel;
      cfg_wdata = data;
      cfg_we    = 1'b1;
      tick(1);
      cfg_we    = 1'b0;
   endtask

   task automatic cfg_chk(input string nm, input logic [1:0] sel, input logic [31:0] exp);
      cfg_sel = sel;
      #1;
      chk(nm, cfg_rdata, exp);
   endtask

   task automatic push(input logic [3:0] id, input int c);
      exp_t e;
      e.id    = id;
      e.cause = 32'h8000_0000 | (32'd16 + 32'(id));
      e.cyc   = c;
      q.push_back(e);
   endtask

   task automatic do_ack();
      intr_ack = 1'b1;
      tick(1);
      intr_ack = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1;
      tick(1);
      eoi = 1'b0;
   endtask

   int c0;

   initial begin
      clrn = 1'b0; intr = '0; intr_ack = 0; eoi = 0;
      cfg_we = 0; cfg_sel = 0; cfg_wdata = '0;
      tick(2);
      chk("rst_int_sync", {31'd0, int_sync}, 32'd0);
      chk("rst_int_id", {28'd0, int_id}, 32'd0);
      chk("rst_int_cause", int_cause, 32'd0);
      cfg_chk("rst_enable", 2'd0, 32'h0);
      cfg_chk("rst_mode", 2'd1, 32'hFF);
      cfg_chk("rst_pend", 2'd2, 32'h0);
      cfg_chk("rst_prio", 2'd3, 32'h0);
      tick(1);
      clrn = 1'b1;
      tick(2);

      // Single edge on source 3
      cfg_write(2'd0, 32'h08);
      cfg_chk("enable_rd", 2'd0, 32'h08);
      c0 = cyc;
      intr[3] = 1'b1;
      push(4'd3, c0 + 4);
      tick(1);
      intr[3] = 1'b0;
      tick(3);
      cfg_chk("t1_pend_set", 2'd2, 32'h08);
      do_ack();
      chk("t1_sync_after_ack", {31'd0, int_sync}, 32'd0);
      cfg_chk("t1_pend_clr", 2'd2, 32'h00);
      do_eoi();

      // Simultaneous sources 1 and 5
      cfg_write(2'd0, 32'hFF);
      c0 = cyc;
      intr[1] = 1'b1; intr[5] = 1'b1;
      push(4'd1, c0 + 4);
      tick(1);
      intr[1] = 1'b0; intr[5] = 1'b0;
      tick(3);
      do_ack();
      cfg_chk("t2_pend_5_left", 2'd2, 32'h20);
      push(4'd5, cyc + 2);
      do_eoi();
      tick(1);
      do_ack();
      do_eoi();
      cfg_chk("t2_pend_empty", 2'd2, 32'h00);

      // Level mode on source 2, then withdraw
      cfg_write(2'd1, 32'hFB);
      c0 = cyc;
      intr[2] = 1'b1;
      push(4'd2, c0 + 3);
      tick(3);
      cfg_chk("t3_level_pend", 2'd2, 32'h04);
      do_ack();
      push(4'd2, cyc + 2);
      do_eoi();
      tick(1);
      intr[2] = 1'b0;
      tick(2);
      chk("t3_sync_before_drop", {31'd0, int_sync}, 32'd1);
      tick(1);
      chk("t3_withdraw", {31'd0, int_sync}, 32'd0);
      tick(3);
      chk("t3_stay_idle", {31'd0, int_sync}, 32'd0);
      cfg_write(2'd1, 32'hFF);

      // Second edge on source 4 coincides with its ack clear
      c0 = cyc;
      intr[4] = 1'b1;
      push(4'd4, c0 + 4);
      tick(1);
      intr[4] = 1'b0;
      tick(1);
      intr[4] = 1'b1;
      tick(1);
      intr[4] = 1'b0;
      tick(1);
      do_ack();
      chk("t4_sync_low", {31'd0, int_sync}, 32'd0);
      cfg_chk("t4_pend_kept", 2'd2, 32'h10);
      push(4'd4, cyc + 2);
      do_eoi();
      tick(1);
      do_ack();
      do_eoi();
      cfg_chk("t4_pend_empty", 2'd2, 32'h00);

      // Masked pending, write-1-clear, write ignoring upper bits
      cfg_write(2'd0, 32'h7F);
      intr[7] = 1'b1;
      tick(1);
      intr[7] = 1'b0;
      tick(4);
      chk("w1c_masked_no_req", {31'd0, int_sync}, 32'd0);
      cfg_chk("w1c_pend_set", 2'd2, 32'h80);
      cfg_write(2'd2, 32'h80);
      cfg_chk("w1c_pend_clr", 2'd2, 32'h00);
      cfg_write(2'd0, 32'hFFFF_FFFF);
      cfg_chk("enable_upper_bits", 2'd0, 32'hFF);

`ifdef INTR_PRIO_EN
      cfg_write(2'd3, 32'h31);
      cfg_chk("prio_rd", 2'd3, 32'h31);
      c0 = cyc;
      intr[0] = 1'b1; intr[2] = 1'b1;
      push(4'd2, c0 + 4);
      tick(1);
      intr[0] = 1'b0; intr[2] = 1'b0;
      tick(3);
      do_ack();
      push(4'd0, cyc + 2);
      do_eoi();
      tick(1);
      do_ack();
      do_eoi();
      cfg_write(2'd3, 32'h0);
`else
      cfg_write(2'd3, 32'h31);
      cfg_chk("prio_absent", 2'd3, 32'h0);
`endif

      // Reset during SERVICE
      c0 = cyc;
      intr[6] = 1'b1;
      push(4'd6, c0 + 4);
      tick(1);
      intr[6] = 1'b0;
      tick(3);
      do_ack();
      chk("t5_id_in_service", {28'd0, int_id}, 32'd6);
      #1 clrn = 1'b0;
      #1;
      chk("t5_rst_sync", {31'd0, int_sync}, 32'd0);
      chk("t5_rst_id", {28'd0, int_id}, 32'd0);
      chk("t5_rst_cause", int_cause, 32'd0);
      tick(1);
      clrn = 1'b1;
      cfg_chk("t5_mode_after", 2'd1, 32'hFF);
      cfg_chk("t5_enable_after", 2'd0, 32'h00);
      tick(6);
      chk("t5_no_req", {31'd0, int_sync}, 32'd0);

      tick(2);
      chk("queue_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
